z80_int_ctrl: RTL

Z80_INT_CTRL -- requirements
Module: z80_int_ctrl

---
 rtl/z80_intc_pkg.sv | 29 ++
 rtl/z80_int_ctrl_if.sv | 23 ++
 rtl/z80_intc_prio.sv | 19 +
 rtl/z80_int_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/z80_intc_pkg.sv
// Shared constants for the Z80 interrupt controller: register offsets, bus FSM states,
// default I/O base and the IM2-style vector builder.
package z80_intc_pkg;

   localparam logic [7:0] BASE_ADDR_DEFAULT = 8'h80;

   localparam logic [1:0] OFF_STATUS = 2'd0;
   localparam logic [1:0] OFF_MASK   = 2'd1;
   localparam logic [1:0] OFF_VBASE  = 2'd2;
   localparam logic [1:0] OFF_ISR    = 2'd3;

   localparam logic [3:0] SPURIOUS_LOW = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_READ     = 3'd1,
      ST_WRITE    = 3'd2,
      ST_ACK      = 3'd3,
      ST_WAIT_END = 3'd4
   } bus_state_t;

   // A spurious acknowledge still hands the CPU a fixed, recognisable vector.
   function automatic logic [7:0] make_vector(input logic [3:0] vbase,
                                              input logic       valid,
                                              input logic [2:0] idx);
      return valid ? {vbase, idx, 1'b0} : {vbase, SPURIOUS_LOW};
   endfunction

endpackage

// File: rtl/z80_int_ctrl_if.sv
// CPU-side bus of the interrupt controller; master = CPU, slave = controller.
interface z80_int_ctrl_if;

   logic        n_iorq;
   logic        n_m1;
   logic        n_rd;
   logic        n_wr;
   logic [15:0] addr;
   logic [7:0]  din;
   logic [7:0]  dout;
   logic        dout_en;

   modport master (
      output n_iorq, n_m1, n_rd, n_wr, addr, din,
      input  dout, dout_en
   );

   modport slave (
      input  n_iorq, n_m1, n_rd, n_wr, addr, din,
      output dout, dout_en
   );

endinterface

// File: rtl/z80_intc_prio.sv
// Fixed-priority encoder: bit 0 wins; o_valid low when no request is present.
module z80_intc_prio (
   input  logic [7:0] i_req,
   output logic [2:0] o_idx,
   output logic       o_valid
);

   always_comb begin
      o_idx   = 3'd0;
      o_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = 3'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 8-source interrupt controller with STATUS/MASK/VBASE/ISR ports and vectored acknowledge.
// Define INTC_EDGE_EN for rising-edge source detection; default build is level-sensitive.
module z80_int_ctrl
   import z80_intc_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 n_reset,
   z80_int_ctrl_if.slave        bus,
   input  logic [7:0]           irq_src,
   output logic                 n_int
);

   bus_state_t r_state;
   logic       r_armed;
   logic [7:0] r_pending;
   logic [7:0] r_mask;
   logic [3:0] r_vbase;
   logic [7:0] r_isr;
   logic [7:0] r_hold;
   logic [7:0] r_dout;
   logic       r_dout_en;
   logic       r_n_int;

   logic [7:0] w_event;
   logic [7:0] w_eligible;
   logic [2:0] w_idx;
   logic       w_valid;
   logic [7:0] w_ack_onehot;
   logic [7:0] w_pending_nxt;
   logic [7:0] w_mask_nxt;
   logic [3:0] w_vbase_nxt;
   logic [7:0] w_isr_nxt;
   logic [7:0] w_rdata;
   logic [1:0] w_off;
   logic       w_sel;
   logic       w_idle_ok;
   logic       w_start_ack;
   logic       w_start_rd;
   logic       w_start_wr;
   logic       w_unused_addr_hi;

   assign w_off            = bus.addr[1:0];
   assign w_sel            = (bus.addr[7:2] == BASE_ADDR[7:2]);
   assign w_unused_addr_hi = ^bus.addr[15:8];

   // r_armed keeps a strobe that was already low across reset release from starting a cycle.
   assign w_idle_ok   = (r_state == ST_IDLE) && r_armed && !bus.n_iorq;
   assign w_start_ack = w_idle_ok && !bus.n_m1;
   assign w_start_rd  = w_idle_ok && bus.n_m1 && !bus.n_rd && w_sel;
   assign w_start_wr  = w_idle_ok && bus.n_m1 && bus.n_rd && !bus.n_wr && w_sel;

`ifdef INTC_EDGE_EN
   logic [7:0] r_irq_prev;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_irq_prev <= '0;
      else          r_irq_prev <= irq_src;
   end

   assign w_event = irq_src & ~r_irq_prev;
`else
   assign w_event = irq_src;
`endif

   assign w_eligible = r_pending & r_mask;

   z80_intc_prio u_prio (
      .i_req   (w_eligible),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   assign w_ack_onehot = (w_start_ack && w_valid) ? (8'd1 << w_idx) : 8'd0;

   // Source events are OR-ed in last so a same-cycle set beats a W1C clear or an acknowledge.
   always_comb begin
      w_pending_nxt = r_pending & ~w_ack_onehot;
      w_isr_nxt     = r_isr | w_ack_onehot;
      w_mask_nxt    = r_mask;
      w_vbase_nxt   = r_vbase;
      if (w_start_wr) begin
         case (w_off)
            OFF_STATUS: w_pending_nxt = w_pending_nxt & ~bus.din;
            OFF_MASK:   w_mask_nxt    = bus.din;
            OFF_VBASE:  w_vbase_nxt   = bus.din[7:4];
            default:    w_isr_nxt     = '0;
         endcase
      end
      w_pending_nxt = w_pending_nxt | w_event;
   end

   always_comb begin
      case (w_off)
         OFF_STATUS: w_rdata = r_pending;
         OFF_MASK:   w_rdata = r_mask;
         OFF_VBASE:  w_rdata = {r_vbase, 4'h0};
         default:    w_rdata = r_isr;
      endcase
   end

   // n_int is derived from the next register values so it always matches the stored state.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_pending <= '0;
         r_mask    <= '0;
         r_vbase   <= '0;
         r_isr     <= '0;
         r_n_int   <= 1'b1;
      end else begin
         r_pending <= w_pending_nxt;
         r_mask    <= w_mask_nxt;
         r_vbase   <= w_vbase_nxt;
         r_isr     <= w_isr_nxt;
         r_n_int   <= !((|(w_pending_nxt & w_mask_nxt)) && (w_isr_nxt == 8'h00));
      end
   end

   // Read/vector data is captured at cycle entry and presented on the following clock.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= ST_IDLE;
         r_armed   <= 1'b0;
         r_hold    <= '0;
         r_dout    <= '0;
         r_dout_en <= 1'b0;
      end else begin
         if (bus.n_iorq) r_armed <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_start_ack) begin
                  r_state <= ST_ACK;
                  r_hold  <= make_vector(r_vbase, w_valid, w_idx);
               end else if (w_start_rd) begin
                  r_state <= ST_READ;
                  r_hold  <= w_rdata;
               end else if (w_start_wr) begin
                  r_state <= ST_WRITE;
               end
            end
            ST_READ, ST_ACK: begin
               if (bus.n_iorq) begin
                  r_state   <= ST_IDLE;
                  r_dout_en <= 1'b0;
               end else if (!r_dout_en) begin
                  r_dout    <= r_hold;
                  r_dout_en <= 1'b1;
               end
            end
            ST_WRITE:    r_state <= ST_WAIT_END;
            ST_WAIT_END: if (bus.n_iorq) r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.dout    = r_dout;
   assign bus.dout_en = r_dout_en;
   assign n_int       = r_n_int;

endmodule
